// File: rtl/udma_jtag_setup_ctrl.sv
`default_nettype none
// ============================================================================
// udma_jtag_setup_ctrl : JTAG setup data register with a four-phase request
// handshake toward the uDMA clock domain. Optional even-parity bit on the
// shift register is compiled in with the JTAG_SETUP_PARITY_EN macro.
// Revision: 1.0
// ============================================================================
module udma_jtag_setup_ctrl #(
    parameter int SETUP_WIDTH = 57,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sel_i,
    input  logic                   capture_dr_i,
    input  logic                   shift_dr_i,
    input  logic                   update_dr_i,
    input  logic                   tdi_i,
    output logic                   tdo_o,
    output logic [SETUP_WIDTH-1:0] setup_value_o,
    output logic                   setup_valid_o,
    input  logic                   setup_ack_i,
    output logic                   busy_o
);

`ifdef JTAG_SETUP_PARITY_EN
    localparam int SW = SETUP_WIDTH + 1;
`else
    localparam int SW = SETUP_WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SW-1:0]          sr;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   do_cap;
    logic                   do_shift;
    logic                   do_upd;
    logic                   upd_ok;
    logic                   parity_ok;
    logic                   drop_sticky;
    logic                   perr_sticky;

    // Capture dominates shift, shift dominates update.
    assign do_cap        = sel_i & capture_dr_i;
    assign do_shift      = sel_i & shift_dr_i & ~capture_dr_i;
    assign do_upd        = sel_i & update_dr_i & ~capture_dr_i & ~shift_dr_i;
    assign ack_s         = ack_sync[SYNC_STAGES-1];
    assign busy_o        = (state != IDLE);
    assign setup_valid_o = (state == REQ);
    assign tdo_o         = sr[0];
    assign upd_ok        = do_upd & (state == IDLE) & parity_ok;

`ifdef JTAG_SETUP_PARITY_EN
    // Even parity: the XOR over every bit including the parity bit is zero.
    assign parity_ok = ~(^sr);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perr_sticky <= 1'b0;
        end else if (do_cap) begin
            perr_sticky <= 1'b0;
        end else if (do_upd && (state == IDLE) && !parity_ok) begin
            perr_sticky <= 1'b1;
        end
    end
`else
    assign parity_ok   = 1'b1;
    assign perr_sticky = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], setup_ack_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr <= '0;
        end else if (do_cap) begin
            sr    <= '0;
            sr[0] <= busy_o;
            sr[1] <= drop_sticky;
            sr[2] <= perr_sticky;
        end else if (do_shift) begin
            sr <= {tdi_i, sr[SW-1:1]};
        end
    end

    // Stickies are sampled into the shift register by capture, so they clear there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_sticky <= 1'b0;
        end else if (do_cap) begin
            drop_sticky <= 1'b0;
        end else if (do_upd && (state != IDLE)) begin
            drop_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            setup_value_o <= '0;
        end else if (upd_ok) begin
            setup_value_o <= sr[SETUP_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (upd_ok) state_next = REQ;
            REQ:     if (ack_s)  state_next = WAIT_LO;
            WAIT_LO: if (!ack_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_udma_jtag_setup_ctrl.sv
`default_nettype none
// ============================================================================
// tb_udma_jtag_setup_ctrl : directed scenarios plus randomized TAP/ack traffic
// compared each cycle against a behavioural model of the setup controller.
// Revision: 1.0
// ============================================================================
module tb_udma_jtag_setup_ctrl;
    localparam int SETUP_WIDTH = 57;
    localparam int SYNC_STAGES = 2;
`ifdef JTAG_SETUP_PARITY_EN
    localparam int SW = SETUP_WIDTH + 1;
`else
    localparam int SW = SETUP_WIDTH;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sel = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0, ack = 1'b0;
    logic tdo, valid, busy;
    logic [SETUP_WIDTH-1:0] value;
    int checks = 0;
    int errors = 0;
    bit auto_ack = 1'b0;

    udma_jtag_setup_ctrl #(.SETUP_WIDTH(SETUP_WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .capture_dr_i(cap), .shift_dr_i(shf),
        .update_dr_i(upd), .tdi_i(tdi), .tdo_o(tdo), .setup_value_o(value),
        .setup_valid_o(valid), .setup_ack_i(ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SW-1:0]          m_sr;
    logic [SETUP_WIDTH-1:0] m_val;
    int                     m_phase;   // 0 idle, 1 requesting, 2 waiting for ack low
    bit                     m_drop, m_perr;
    bit                     ack_hist[$];

    task automatic model_step();
        bit acks;
        bit bsy;
        if (rst) begin
            m_sr = '0; m_val = '0; m_phase = 0; m_drop = 0; m_perr = 0;
            ack_hist = {};
            repeat (SYNC_STAGES) ack_hist.push_back(1'b0);
            return;
        end
        // The controller reacts to the ack value sampled SYNC_STAGES edges earlier.
        acks = (ack_hist.size() > 0) ? ack_hist.pop_front() : 1'b0;
        ack_hist.push_back(ack);
        bsy = (m_phase != 0);
        if (sel && cap) begin
            m_sr = '0;
            m_sr[0] = bsy; m_sr[1] = m_drop; m_sr[2] = m_perr;
            m_drop = 0; m_perr = 0;
        end else if (sel && shf) begin
            m_sr = {tdi, m_sr[SW-1:1]};
        end else if (sel && upd) begin
            if (bsy) m_drop = 1;
`ifdef JTAG_SETUP_PARITY_EN
            else if ((^m_sr) != 1'b0) m_perr = 1;
`endif
            else begin
                m_val = m_sr[SETUP_WIDTH-1:0];
                m_phase = 1;
                return;
            end
        end
        if (m_phase == 1 && acks) m_phase = 2;
        else if (m_phase == 2 && !acks) m_phase = 0;
    endtask

    always @(posedge clk or posedge rst) model_step();

    always @(negedge clk) begin
        chk("tdo", {63'd0, tdo}, {63'd0, m_sr[0]});
        chk("setup_value", {7'd0, value}, {7'd0, m_val});
        chk("setup_valid", {63'd0, valid}, {63'd0, (m_phase == 1)});
        chk("busy", {63'd0, busy}, {63'd0, (m_phase != 0)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            if (valid) begin
                if ($urandom_range(2) == 0) ack = 1'b1;
            end else if (ack) begin
                if ($urandom_range(2) == 0) ack = 1'b0;
            end else if (!busy && $urandom_range(15) == 0) begin
                ack = 1'b1;
            end
        end
    endtask

    function automatic logic [SW-1:0] mkword(input logic [SETUP_WIDTH-1:0] v);
`ifdef JTAG_SETUP_PARITY_EN
        return {^v, v};
`else
        return v;
`endif
    endfunction

    task automatic shift_word(input logic [SW-1:0] w);
        sel = 1; shf = 1;
        for (int i = 0; i < SW; i++) begin
            tdi = w[i];
            tick();
        end
        shf = 0; tdi = 0;
    endtask

    task automatic do_update();
        sel = 1; upd = 1; tick(); upd = 0;
    endtask

    task automatic do_capture();
        sel = 1; cap = 1; tick(); cap = 0;
    endtask

    task automatic read_status(output logic [2:0] b);
        b[0] = tdo;
        sel = 1; shf = 1; tdi = 0;
        tick(); b[1] = tdo;
        tick(); b[2] = tdo;
        shf = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    localparam logic [SETUP_WIDTH-1:0] W1 = 57'h0A_0000_1000_0100;

    initial begin
        logic [2:0] st;
        logic [SETUP_WIDTH-1:0] w2, w3;
        int n;
        rst = 1'b1;
        repeat (SYNC_STAGES) ack_hist.push_back(1'b0);
        tick(); tick();
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_value", {7'd0, value}, 64'd0);
        chk("reset_tdo", {63'd0, tdo}, 64'd0);
        rst = 1'b0;
        tick();

        // First command, value visible one cycle after update.
        shift_word(mkword(W1));
        do_update();
        chk("cmd1_value", {7'd0, value}, 64'h000A_0000_1000_0100);
        chk("cmd1_valid", {63'd0, valid}, 64'd1);
        chk("cmd1_busy", {63'd0, busy}, 64'd1);

        // Handshake timing through the synchronizer.
        tick(); tick(); tick();
        ack = 1;
        n = 0;
        while (valid && n < 20) begin tick(); n++; end
        chk("valid_fall_lat", 64'(n), 64'(SYNC_STAGES + 1));
        ack = 0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("idle_return_lat", 64'(n), 64'(SYNC_STAGES + 1));

        // Ack high while idle is ignored.
        ack = 1;
        repeat (5) tick();
        chk("idle_ack_ignored", {63'd0, busy}, 64'd0);
        ack = 0;
        repeat (SYNC_STAGES + 1) tick();

        // Update while busy is dropped and reported.
        w2 = 57'h1_2345_6789_ABCD;
        w3 = 57'h0_0F0F_0F0F_0F0F;
        shift_word(mkword(w2));
        do_update();
        shift_word(mkword(w3));
        do_update();
        chk("drop_value_kept", {7'd0, value}, {7'd0, w2});
        ack = 1;
        repeat (SYNC_STAGES + 2) tick();
        ack = 0;
        wait_idle("drop_idle");
        do_capture();
        read_status(st);
        chk("status_drop", {61'd0, st}, 64'd2);
        do_capture();
        read_status(st);
        chk("status_clear", {61'd0, st}, 64'd0);

        // All strobes together: capture only.
        shift_word(mkword(w3));
        sel = 1; cap = 1; shf = 1; upd = 1;
        tick();
        cap = 0; shf = 0; upd = 0;
        chk("triple_tdo", {63'd0, tdo}, 64'd0);
        tick(); tick();
        chk("triple_no_req", {63'd0, valid}, 64'd0);
        chk("triple_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a request.
        shift_word(mkword(w3));
        do_update();
        chk("pre_rst_valid", {63'd0, valid}, 64'd1);
        rst = 1;
        #1;
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_value", {7'd0, value}, 64'd0);
        chk("rst_tdo", {63'd0, tdo}, 64'd0);
        tick();
        rst = 0;
        ack = 0;
        tick();
        shift_word(mkword(w2));
        do_update();
        chk("post_rst_value", {7'd0, value}, {7'd0, w2});
        chk("post_rst_valid", {63'd0, valid}, 64'd1);
        auto_ack = 1;
        wait_idle("post_rst_complete");
        auto_ack = 0;
        ack = 0;
        repeat (SYNC_STAGES + 2) tick();

`ifdef JTAG_SETUP_PARITY_EN
        begin
            logic [SW-1:0] bad;
            bad = mkword(w3);
            bad[SETUP_WIDTH] = ~bad[SETUP_WIDTH];
            shift_word(bad);
            do_update();
            chk("perr_no_valid", {63'd0, valid}, 64'd0);
            chk("perr_idle", {63'd0, busy}, 64'd0);
            do_capture();
            read_status(st);
            chk("status_perr", {61'd0, st}, 64'd4);
            shift_word(mkword(w3));
            do_update();
            chk("parity_ok_valid", {63'd0, valid}, 64'd1);
            chk("parity_ok_value", {7'd0, value}, {7'd0, w3});
            auto_ack = 1;
            wait_idle("parity_complete");
        end
`endif

        // Randomized traffic.
        auto_ack = 1;
        for (int it = 0; it < 400; it++) begin
            int op;
            op = $urandom_range(0, 11);
            sel = ($urandom_range(7) != 0);
            case (op)
                0, 1, 2: begin
                    shf = 1;
                    repeat ($urandom_range(1, SW + 3)) begin
                        tdi = $urandom_range(1);
                        tick();
                    end
                    shf = 0;
                end
                3: begin
                    shift_word(mkword({$urandom, $urandom}));
                    do_update();
                end
                4, 5: begin upd = 1; tick(); upd = 0; end
                6: begin cap = 1; tick(); cap = 0; end
                7: begin
                    cap = $urandom_range(1); shf = $urandom_range(1); upd = $urandom_range(1);
                    tdi = $urandom_range(1);
                    tick();
                    cap = 0; shf = 0; upd = 0;
                end
                8, 9, 10: repeat ($urandom_range(1, 4)) tick();
                default: begin
                    if ($urandom_range(3) == 0) begin
                        rst = 1; tick(); rst = 0;
                    end
                    tick();
                end
            endcase
        end
        auto_ack = 1;
        sel = 0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
